// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the SRAM arbiter slice.
package sram_arb_pkg;

   localparam int unsigned AddrWidth   = 18;
   localparam int unsigned DataWidth   = 16;
   localparam int unsigned WaitDefault = 1;

   // Access sequencer states.
   typedef enum logic [1:0] {
      StIdle,
      StAcc,
      StAck
   } state_e;

endpackage

// File: rtl/sram_arb_if.sv
// CPU, video and SRAM-pad signal bundle for sram_arb.
// master: the requesters plus the SRAM device; slave: the arbiter itself.
interface sram_arb_if;
   import sram_arb_pkg::*;

   logic                 cpu_req;
   logic [1:0]           cpu_we;
   logic [AddrWidth-1:0] cpu_addr;
   logic [DataWidth-1:0] cpu_wdata;
   logic [DataWidth-1:0] cpu_rdata;
   logic                 cpu_ack;

   logic                 vid_req;
   logic [AddrWidth-1:0] vid_addr;
   logic [DataWidth-1:0] vid_rdata;
   logic                 vid_ack;

   logic [AddrWidth-1:0] sram_addr;
   logic [DataWidth-1:0] sram_dq_i;
   logic [DataWidth-1:0] sram_dq_o;
   logic                 sram_dq_oe;
   logic                 sram_ce_n;
   logic                 sram_oe_n;
   logic                 sram_we_n;
   logic                 sram_ub_n;
   logic                 sram_lb_n;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
      input  cpu_rdata, cpu_ack, vid_rdata, vid_ack, sram_addr, sram_dq_o, sram_dq_oe,
      input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
      output cpu_rdata, cpu_ack, vid_rdata, vid_ack, sram_addr, sram_dq_o, sram_dq_oe,
      output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
   );

endinterface

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter. req[0] = CPU, req[1] = video.
// Grant is combinational; the last-granted pointer moves only on advance.
module sram_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_vid_q, last_vid_d;

   // Pick a winner; on a tie the side not granted last wins.
   always_comb begin
      grant      = 2'b00;
      last_vid_d = last_vid_q;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_vid_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      if (advance && (grant != 2'b00)) begin
         last_vid_d = grant[1];
      end
   end

   // Last-granted pointer, cleared to CPU so video wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_vid_q <= 1'b0;
      end else begin
         last_vid_q <= last_vid_d;
      end
   end

endmodule

// File: rtl/sram_arb.sv
// Shares one asynchronous 16-bit SRAM between a CPU port and a read-only
// video port. Each access is IDLE -> ACC (WAIT+1 cycles) -> ACK.
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int unsigned WAIT = WaitDefault
) (
   input logic       clk,
   input logic       reset,
   sram_arb_if.slave bus
);

   state_e               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 own_vid_q, own_vid_d;
   logic [1:0]           we_q, we_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [DataWidth-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DataWidth-1:0] vid_rdata_q, vid_rdata_d;

   logic [1:0] grant;
   logic       advance;
   logic       in_acc;
   logic       is_rd;

   sram_rr_arb u_rr_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({bus.vid_req, bus.cpu_req}),
      .advance (advance),
      .grant   (grant)
   );

   // Next state: latch the winner's request on grant, count down ACC, capture read data.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      own_vid_d   = own_vid_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      vid_rdata_d = vid_rdata_q;
      advance     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant != 2'b00) begin
               advance   = 1'b1;
               state_d   = StAcc;
               cnt_d     = 3'(WAIT);
               own_vid_d = grant[1];
               if (grant[1]) begin
                  addr_d = bus.vid_addr;
                  we_d   = 2'b00;
               end else begin
                  addr_d  = bus.cpu_addr;
                  we_d    = bus.cpu_we;
                  wdata_d = bus.cpu_wdata;
               end
            end
         end
         StAcc: begin
            if (cnt_q == 3'd0) begin
               state_d = StAck;
               // Last strobe cycle: the SRAM output has settled.
               if (we_q == 2'b00) begin
                  if (own_vid_q) begin
                     vid_rdata_d = bus.sram_dq_i;
                  end else begin
                     cpu_rdata_d = bus.sram_dq_i;
                  end
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Pad strobes and acks decoded from the registered state only.
   always_comb begin
      in_acc         = (state_q == StAcc);
      is_rd          = (we_q == 2'b00);
      bus.sram_addr  = addr_q;
      bus.sram_dq_o  = wdata_q;
      // Writes keep driving through ACK so data holds one cycle past we_n rising.
      bus.sram_dq_oe = !is_rd && (state_q != StIdle);
      bus.sram_ce_n  = !in_acc;
      bus.sram_oe_n  = !(in_acc && is_rd);
      bus.sram_we_n  = !(in_acc && !is_rd);
      bus.sram_ub_n  = !(in_acc && (is_rd || we_q[1]));
      bus.sram_lb_n  = !(in_acc && (is_rd || we_q[0]));
      bus.cpu_ack    = (state_q == StAck) && !own_vid_q;
      bus.vid_ack    = (state_q == StAck) && own_vid_q;
      bus.cpu_rdata  = cpu_rdata_q;
      bus.vid_rdata  = vid_rdata_q;
   end

   // State registers; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         own_vid_q   <= 1'b0;
         we_q        <= 2'b00;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         own_vid_q   <= own_vid_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_rdata_q <= vid_rdata_d;
      end
   end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter WAIT, default 1: extra SRAM strobe cycles per access; legal range 0..7.
REQ-002 clk  in  1  single system clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU access request, held high until cpu_ack.
REQ-005 cpu_we  in  2  byte write strobes {hi,lo}; 2'b00 = read.
REQ-006 cpu_addr  in  18  CPU word address.
REQ-007 cpu_wdata  in  16  CPU write data.
REQ-008 cpu_rdata  out  16  CPU read data, valid while cpu_ack=1.
REQ-009 cpu_ack  out  1  one-cycle completion pulse.
REQ-010 vid_req  in  1  video/DMA read request, held until vid_ack.
REQ-011 vid_addr  in  18  video word address.
REQ-012 vid_rdata  out  16  video read data, valid while vid_ack=1.
REQ-013 vid_ack  out  1  one-cycle completion pulse.
REQ-014 sram_addr  out  18; sram_dq_i  in  16; sram_dq_o  out  16; sram_dq_oe  out  1 (pad tristate control, at top level).
REQ-015 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each, active-low SRAM strobes.

Function
REQ-016 The FSM SHALL have states IDLE, ACC, ACK; IDLE->ACC on grant, ACC->ACK when wait counter reaches 0, ACK->IDLE unconditionally.
REQ-017 On grant, the block SHALL latch requester, address, byte strobes and write data; later input changes SHALL NOT affect the current access.
REQ-018 ACC SHALL last exactly WAIT+1 cycles, using a counter loaded with WAIT and decremented to 0.
REQ-019 Latency: request sampled in IDLE at edge N -> ack high in cycle N+WAIT+2 (WAIT=1: 3 cycles).
REQ-020 Read: ce_n=0, oe_n=0, ub_n=lb_n=0 throughout ACC; sram_dq_i SHALL be registered on the last ACC cycle and presented in ACK.
REQ-021 Write: ce_n=0, we_n=0 during ACC only; ub_n=~cpu_we[1], lb_n=~cpu_we[0]; sram_dq_oe=1 and addr/data held through ACC and ACK (one-cycle hold after we_n rises).
REQ-022 sram_oe_n=0 and sram_dq_oe=1 SHALL never be asserted in the same cycle.
REQ-023 In IDLE all strobes SHALL be 1 and sram_dq_oe 0 (one bus turnaround cycle between accesses).
REQ-024 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the requester not granted last wins; last-granted resets to CPU, so video wins the first tie.
REQ-025 Back-to-back: a requester holding req through ack SHALL be re-considered in the IDLE cycle after ACK; ack-to-next-ack spacing is WAIT+3 cycles.
REQ-026 Only the granted requester's ack SHALL pulse; both acks SHALL never be high together.
REQ-027 rdata outputs SHALL hold their last value outside ACK.

Reset
REQ-028 On reset: state IDLE, counter 0, last-granted CPU, all SRAM strobes 1, sram_dq_oe 0, sram_addr 0, sram_dq_o 0, acks 0, rdata 0.
REQ-029 Reset asserted mid-access SHALL abort it at that edge with no ack issued and no further strobe cycles.

Structure
REQ-030 A shared package SHALL hold the state enum, WAIT default, address width (18) and data width (16).
REQ-031 The two-input round-robin arbiter SHALL be a sub-module sram_rr_arb (inputs req[1:0], advance; output grant[1:0]).

Verification
REQ-032 CPU read, WAIT=1, addr 18'h00123, sram_dq_i=16'hBEEF -> oe_n low 2 cycles, cpu_ack 3 cycles after req, cpu_rdata=16'hBEEF.
REQ-033 CPU write cpu_we=2'b10, data 16'hA55A, addr 18'h3FFFF -> we_n low 2 cycles, ub_n=0, lb_n=1, dq_oe high 3 cycles, sram_dq_o=16'hA55A.
REQ-034 cpu_req and vid_req both held high after reset -> grants alternate vid, cpu, vid, cpu; acks spaced 4 cycles (WAIT=1).
REQ-035 Reset pulsed during ACC of a write -> next cycle all strobes 1, dq_oe 0, no cpu_ack.
REQ-036 WAIT=0, vid read addr 18'h00000 -> ACC 1 cycle, vid_ack 2 cycles after req; checker asserts oe_n/dq_oe never overlap throughout.
